sdram_req_arbiter: RTL and testbench
====================================

// Module: sdram_req_arbiter
// PURPOSE
//  Shares the single LLC-side port of the DDR4 SDRAM controller between NUM_REQ requesters.
//  Round-robin grant, one request per ISSUE_GAP window (controller must not see traffic while busy).
//  Periodic refresh blackout windows. In-order read responses routed back by a requester-ID FIFO.
// PARAMETERS
//  NUM_REQ           4     number of requesters (>=2)
//  PADDR_BITS        19    request address width; MSB = write flag (1 write, 0 read)
//  DATA_BITS         64    write/read data width
//  ISSUE_GAP         4     idle cycles enforced after each issued request (>=1)
//  REFRESH_INTERVAL  1024  cycles between refresh windows
//  REFRESH_CYCLES    16    length of refresh blackout window
//  RSP_DEPTH         8     depth of outstanding-read ID FIFO (power of 2)
// PORTS
//  clk_in              in   1                    clock
//  rst_N_in            in   1                    reset, asynchronous, active-high
//  req_valid_in        in   NUM_REQ              per-requester request valid
//  req_addr_in         in   NUM_REQ*PADDR_BITS   per-requester address (packed, req 0 in LSBs)
//  req_wdata_in        in   NUM_REQ*DATA_BITS    per-requester write data (packed)
//  req_ready_out       out  NUM_REQ              one-hot accept pulse
//  ctrl_ready_in       in   1                    controller can take a request
//  ctrl_valid_out      out  1                    request to controller
//  ctrl_addr_out       out  PADDR_BITS           granted address
//  ctrl_wdata_out      out  DATA_BITS            granted write data
//  ctrl_rvalid_in      in   1                    controller read data valid
//  ctrl_rdata_in       in   DATA_BITS            controller read data
//  rsp_valid_out       out  NUM_REQ              one-hot read-response valid
//  rsp_data_out        out  DATA_BITS            read data, common to all requesters
//  refresh_active_out  out  1                    high during refresh window
//  grant_id_out        out  $clog2(NUM_REQ)      ID of the last granted requester
//  rsp_err_out         out  1                    sticky: rvalid received with ID FIFO empty
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr_ptr=0, refresh counter=0, gap counter=0, ID FIFO empty.
//  Reset mid-operation drops in-flight grants and outstanding IDs, with no response emitted.
//  States: IDLE, ISSUE, HOLD, REFRESH.
//  Refresh counter:
//   - Increments every cycle and saturates at REFRESH_INTERVAL.
//   - refresh_due = (count == REFRESH_INTERVAL).
//  IDLE, priority order:
//   - refresh_due -> REFRESH, counter cleared.
//   - Else eligible requester exists and ctrl_ready_in=1: grant first eligible index starting
//     at rr_ptr, wrapping NUM_REQ-1 -> 0.
//  Eligible = req_valid_in[i] && (write || ID FIFO not full).
//   - A full FIFO masks reads only. Writes remain eligible.
//  Grant cycle N (combinational):
//   - req_ready_out[g]=1.
//   - Addr/data/g registered.
//   - rr_ptr <= (g+1) mod NUM_REQ.
//   - grant_id_out <= g.
//   - Read: push g into ID FIFO.
//  ISSUE (cycle N+1):
//   - ctrl_valid_out=1 for exactly one cycle, with registered addr/wdata.
//   - Then HOLD.
//  HOLD:
//   - Gap counter runs ISSUE_GAP cycles, then IDLE.
//   - No new grant is possible before cycle N+2+ISSUE_GAP.
//  REFRESH:
//   - refresh_active_out=1 for exactly REFRESH_CYCLES cycles, then IDLE.
//   - No grants during REFRESH.
//  Refresh never preempts ISSUE/HOLD. A due refresh waits for IDLE and beats a same-cycle request.
//  ctrl_ready_in=0 in IDLE: no grant, rr_ptr unchanged.
//  Read return:
//   - On ctrl_rvalid_in, pop FIFO head h.
//   - Next cycle rsp_valid_out[h]=1 and rsp_data_out=ctrl_rdata_in (1-cycle registered latency).
//  FIFO: push and pop in the same cycle are both performed, with occupancy unchanged.
//  rvalid with FIFO empty: no response, rsp_err_out set until reset.
//  ctrl_addr_out/ctrl_wdata_out hold their value outside ISSUE. rsp_data_out holds its last value.
// TESTING
//  1. Reqs 0,2 valid (reads) from reset, ctrl_ready=1 -> grants 0 then 2; ctrl_valid pulses 1+ISSUE_GAP+1=6 cycles apart.
//  2. All 4 valid continuously -> grant order 0,1,2,3,0; grant_id_out follows; no requester starves.
//  3. Req 1 reads 0x00010 then 0x00020; two ctrl_rvalid with 0xAAAA, 0xBBBB -> rsp_valid_out=4'b0010 twice, data in order.
//  4. 8 reads outstanding (FIFO full), req 3 read, req 1 write (addr 0x40000) -> write granted, read blocked until a pop.
//  5. Counter reaches 1024 while req 0 valid in IDLE -> refresh_active 16 cycles first, then grant 0.
//  6. rst_N_in pulsed during HOLD with 2 reads outstanding -> outputs 0; later rvalid sets rsp_err_out, no rsp_valid.

Source files
------------

// File: rtl/sdram_req_arbiter.sv
// Round-robin arbiter sharing the single controller port among NUM_REQ requesters,
// with issue spacing, periodic refresh blackout and in-order read-response routing.
module sdram_req_arbiter #(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned PADDR_BITS       = 19,
  parameter int unsigned DATA_BITS        = 64,
  parameter int unsigned ISSUE_GAP        = 4,
  parameter int unsigned REFRESH_INTERVAL = 1024,
  parameter int unsigned REFRESH_CYCLES   = 16,
  parameter int unsigned RSP_DEPTH        = 8
) (
  input  logic                            clk_in,
  input  logic                            rst_N_in,
  input  logic [NUM_REQ-1:0]              req_valid_in,
  input  logic [NUM_REQ*PADDR_BITS-1:0]   req_addr_in,
  input  logic [NUM_REQ*DATA_BITS-1:0]    req_wdata_in,
  output logic [NUM_REQ-1:0]              req_ready_out,
  input  logic                            ctrl_ready_in,
  output logic                            ctrl_valid_out,
  output logic [PADDR_BITS-1:0]           ctrl_addr_out,
  output logic [DATA_BITS-1:0]            ctrl_wdata_out,
  input  logic                            ctrl_rvalid_in,
  input  logic [DATA_BITS-1:0]            ctrl_rdata_in,
  output logic [NUM_REQ-1:0]              rsp_valid_out,
  output logic [DATA_BITS-1:0]            rsp_data_out,
  output logic                            refresh_active_out,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id_out,
  output logic                            rsp_err_out
);

  localparam int unsigned IDW  = $clog2(NUM_REQ);
  localparam int unsigned RCW  = $clog2(REFRESH_INTERVAL + 1);
  localparam int unsigned WMAX = (ISSUE_GAP > REFRESH_CYCLES) ? ISSUE_GAP : REFRESH_CYCLES;
  localparam int unsigned WCW  = $clog2(WMAX + 1);
  localparam int unsigned FAW  = $clog2(RSP_DEPTH);
  localparam int unsigned FCW  = FAW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_REFRESH} state_t;

  state_t                 state_q, state_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [WCW-1:0]         wait_q, wait_d;
  logic [RCW-1:0]         refcnt_q;
  logic                   refresh_due, refcnt_clr;
  logic [NUM_REQ-1:0]     elig;
  logic [IDW:0]           rr_idx;
  logic [IDW-1:0]         pick, gid_q, head;
  logic                   found, grant, push, pop;
  logic [PADDR_BITS-1:0]  sel_addr, addr_q;
  logic [DATA_BITS-1:0]   sel_wdata, wdata_q, rsp_data_q;
  logic [IDW-1:0]         fifo_q [RSP_DEPTH];
  logic [FAW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [FCW-1:0]         fcnt_q;
  logic                   fifo_full, fifo_empty;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic                   err_q;

  assign fifo_full   = (fcnt_q == FCW'(RSP_DEPTH));
  assign fifo_empty  = (fcnt_q == '0);
  assign refresh_due = (refcnt_q == RCW'(REFRESH_INTERVAL));
  assign head        = fifo_q[rd_ptr_q];
  assign sel_addr    = req_addr_in[int'(pick)*PADDR_BITS +: PADDR_BITS];
  assign sel_wdata   = req_wdata_in[int'(pick)*DATA_BITS +: DATA_BITS];

  // A full ID FIFO masks reads only; writes need no response slot
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid_in[i] & (req_addr_in[i*PADDR_BITS + PADDR_BITS - 1] | ~fifo_full);
    end
  end

  // First eligible requester scanning from rr_ptr with wrap
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (rr_idx >= (IDW+1)'(NUM_REQ)) rr_idx = rr_idx - (IDW+1)'(NUM_REQ);
      if (!found && elig[rr_idx[IDW-1:0]]) begin
        found = 1'b1;
        pick  = rr_idx[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_N_in) begin
    if (rst_N_in) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    wait_d        = wait_q;
    grant         = 1'b0;
    refcnt_clr    = 1'b0;
    req_ready_out = '0;
    case (state_q)
      S_IDLE: begin
        if (refresh_due) begin
          state_d    = S_REFRESH;
          wait_d     = '0;
          refcnt_clr = 1'b1;
        end else if (found && ctrl_ready_in) begin
          grant               = 1'b1;
          req_ready_out[pick] = 1'b1;
          rr_ptr_d            = (pick == IDW'(NUM_REQ - 1)) ? '0 : pick + IDW'(1);
          state_d             = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_HOLD;
        wait_d  = '0;
      end
      S_HOLD: begin
        if (wait_q == WCW'(ISSUE_GAP - 1)) state_d = S_IDLE;
        else                               wait_d  = wait_q + WCW'(1);
      end
      S_REFRESH: begin
        if (wait_q == WCW'(REFRESH_CYCLES - 1)) state_d = S_IDLE;
        else                                    wait_d  = wait_q + WCW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign push = grant & ~sel_addr[PADDR_BITS-1];
  assign pop  = ctrl_rvalid_in & ~fifo_empty;

  always_comb begin
    rsp_valid_d = '0;
    if (pop) rsp_valid_d[head] = 1'b1;
  end

  // ID storage needs no reset: occupancy and pointers define validity
  always_ff @(posedge clk_in) begin
    if (push) fifo_q[wr_ptr_q] <= pick;
  end

  always_ff @(posedge clk_in or posedge rst_N_in) begin
    if (rst_N_in) begin
      refcnt_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gid_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcnt_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      if (refcnt_clr)                               refcnt_q <= '0;
      else if (refcnt_q != RCW'(REFRESH_INTERVAL))  refcnt_q <= refcnt_q + RCW'(1);
      if (grant) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        gid_q   <= pick;
      end
      if (push) wr_ptr_q <= wr_ptr_q + FAW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FAW'(1);
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + FCW'(1);
        2'b01:   fcnt_q <= fcnt_q - FCW'(1);
        default: fcnt_q <= fcnt_q;
      endcase
      rsp_valid_q <= rsp_valid_d;
      if (pop) rsp_data_q <= ctrl_rdata_in;
      if (ctrl_rvalid_in && fifo_empty) err_q <= 1'b1;
    end
  end

  assign ctrl_valid_out     = (state_q == S_ISSUE);
  assign refresh_active_out = (state_q == S_REFRESH);
  assign ctrl_addr_out      = addr_q;
  assign ctrl_wdata_out     = wdata_q;
  assign grant_id_out       = gid_q;
  assign rsp_valid_out      = rsp_valid_q;
  assign rsp_data_out       = rsp_data_q;
  assign rsp_err_out        = err_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter: a per-cycle vector table for the basic
// grant/issue/response path plus hand-written multi-cycle sequences.
module tb_sdram_req_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 19;
  localparam int unsigned DW = 64;

  logic             clk_in = 1'b0;
  logic             rst_N_in = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    req_ready_out;
  logic             ctrl_ready = 1'b1;
  logic             ctrl_valid_out;
  logic [AW-1:0]    ctrl_addr_out;
  logic [DW-1:0]    ctrl_wdata_out;
  logic             rvalid = 1'b0;
  logic [DW-1:0]    rdata = '0;
  logic [NR-1:0]    rsp_valid_out;
  logic [DW-1:0]    rsp_data_out;
  logic             refresh_active_out;
  logic [1:0]       grant_id_out;
  logic             rsp_err_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;

  sdram_req_arbiter dut (
    .clk_in             (clk_in),
    .rst_N_in           (rst_N_in),
    .req_valid_in       (req_valid),
    .req_addr_in        (req_addr),
    .req_wdata_in       (req_wdata),
    .req_ready_out      (req_ready_out),
    .ctrl_ready_in      (ctrl_ready),
    .ctrl_valid_out     (ctrl_valid_out),
    .ctrl_addr_out      (ctrl_addr_out),
    .ctrl_wdata_out     (ctrl_wdata_out),
    .ctrl_rvalid_in     (rvalid),
    .ctrl_rdata_in      (rdata),
    .rsp_valid_out      (rsp_valid_out),
    .rsp_data_out       (rsp_data_out),
    .refresh_active_out (refresh_active_out),
    .grant_id_out       (grant_id_out),
    .rsp_err_out        (rsp_err_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic [3:0]  valid;
    logic        rv;
    logic [63:0] rd;
    logic [3:0]  e_ready;
    logic        e_cvalid;
    logic [1:0]  e_gid;
    logic [18:0] e_addr;
    logic [3:0]  e_rsp;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t tv [13];

  function automatic vec_t mk(input logic [3:0] v, input logic rv, input logic [63:0] rd,
                              input logic [3:0] er, input logic ec, input logic [1:0] eg,
                              input logic [18:0] ea, input logic [3:0] es, input logic [63:0] ed);
    vec_t t;
    t.valid = v; t.rv = rv; t.rd = rd; t.e_ready = er; t.e_cvalid = ec;
    t.e_gid = eg; t.e_addr = ea; t.e_rsp = es; t.e_rdata = ed;
    return t;
  endfunction

  // Inputs are driven at posedge+1, outputs sampled at posedge+3
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_N_in = 1'b1;
    req_valid = '0;
    rvalid = 1'b0;
    rdata = '0;
    ctrl_ready = 1'b1;
    tick();
    tick();
    rst_N_in = 1'b0;
  endtask

  // Entered at a drive point; returns at the sample point of the grant cycle
  task automatic wait_ready(input string nm, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      #2;
      if (req_ready_out != '0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no grant within 40 cycles", nm);
      #2;
    end
  endtask

  task automatic do_grant(input int r, input logic [18:0] a, input logic [63:0] d, input string nm);
    bit ok;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
    req_valid[r] = 1'b1;
    wait_ready(nm, ok);
    chk({nm, "_ready"}, 64'(req_ready_out), 64'(4'b0001 << r));
    tick();
    req_valid[r] = 1'b0;
    #2;
    chk({nm, "_cvalid"}, 64'(ctrl_valid_out), 64'd1);
    chk({nm, "_addr"}, 64'(ctrl_addr_out), 64'(a));
    chk({nm, "_wdata"}, ctrl_wdata_out, d);
    chk({nm, "_gid"}, 64'(grant_id_out), 64'(r));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    bit seen;
    int last_cyc;

    tv[0]  = mk(4'b0101, 1'b0, 64'h0,    4'b0001, 1'b0, 2'd0, 19'h00000, 4'b0000, 64'h0);
    tv[1]  = mk(4'b0100, 1'b0, 64'h0,    4'b0000, 1'b1, 2'd0, 19'h00100, 4'b0000, 64'h0);
    tv[2]  = mk(4'b0100, 1'b0, 64'h0,    4'b0000, 1'b0, 2'd0, 19'h00100, 4'b0000, 64'h0);
    tv[3]  = tv[2];
    tv[4]  = tv[2];
    tv[5]  = tv[2];
    tv[6]  = mk(4'b0100, 1'b0, 64'h0,    4'b0100, 1'b0, 2'd0, 19'h00100, 4'b0000, 64'h0);
    tv[7]  = mk(4'b0000, 1'b0, 64'h0,    4'b0000, 1'b1, 2'd2, 19'h00200, 4'b0000, 64'h0);
    tv[8]  = mk(4'b0000, 1'b0, 64'h0,    4'b0000, 1'b0, 2'd2, 19'h00200, 4'b0000, 64'h0);
    tv[9]  = mk(4'b0000, 1'b1, 64'h1111, 4'b0000, 1'b0, 2'd2, 19'h00200, 4'b0000, 64'h0);
    tv[10] = mk(4'b0000, 1'b1, 64'h2222, 4'b0000, 1'b0, 2'd2, 19'h00200, 4'b0001, 64'h1111);
    tv[11] = mk(4'b0000, 1'b0, 64'h0,    4'b0000, 1'b0, 2'd2, 19'h00200, 4'b0100, 64'h2222);
    tv[12] = mk(4'b0000, 1'b0, 64'h0,    4'b0000, 1'b0, 2'd2, 19'h00200, 4'b0000, 64'h2222);

    // Reset values
    tick();
    tick();
    #2;
    chk("rst_ready",   64'(req_ready_out), 64'd0);
    chk("rst_cvalid",  64'(ctrl_valid_out), 64'd0);
    chk("rst_addr",    64'(ctrl_addr_out), 64'd0);
    chk("rst_wdata",   ctrl_wdata_out, 64'd0);
    chk("rst_rsp",     64'(rsp_valid_out), 64'd0);
    chk("rst_rdata",   rsp_data_out, 64'd0);
    chk("rst_refresh", 64'(refresh_active_out), 64'd0);
    chk("rst_gid",     64'(grant_id_out), 64'd0);
    chk("rst_err",     64'(rsp_err_out), 64'd0);
    tick();
    rst_N_in = 1'b0;

    // Reads from 0 and 2, then their responses, cycle by cycle
    req_addr[0*AW +: AW] = 19'h00100;
    req_addr[2*AW +: AW] = 19'h00200;
    for (int i = 0; i < 13; i++) begin
      req_valid = tv[i].valid;
      rvalid    = tv[i].rv;
      rdata     = tv[i].rd;
      #2;
      chk($sformatf("t1_ready[%0d]", i),  64'(req_ready_out), 64'(tv[i].e_ready));
      chk($sformatf("t1_cvalid[%0d]", i), 64'(ctrl_valid_out), 64'(tv[i].e_cvalid));
      chk($sformatf("t1_gid[%0d]", i),    64'(grant_id_out), 64'(tv[i].e_gid));
      chk($sformatf("t1_addr[%0d]", i),   64'(ctrl_addr_out), 64'(tv[i].e_addr));
      chk($sformatf("t1_rsp[%0d]", i),    64'(rsp_valid_out), 64'(tv[i].e_rsp));
      chk($sformatf("t1_rdata[%0d]", i),  rsp_data_out, tv[i].e_rdata);
      tick();
    end

    // All four requesters continuously valid with writes: order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = 19'h40000 | 19'(i * 16);
      req_wdata[i*DW +: DW] = 64'hD0 + 64'(i);
    end
    req_valid = 4'b1111;
    last_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ready($sformatf("t2_wait%0d", k), ok);
      chk($sformatf("t2_ready%0d", k), 64'(req_ready_out), 64'(4'b0001 << (k % 4)));
      if (k > 0) chk($sformatf("t2_spacing%0d", k), 64'(cyc_cnt - last_cyc), 64'd6);
      last_cyc = cyc_cnt;
      tick();
      #2;
      chk($sformatf("t2_cvalid%0d", k), 64'(ctrl_valid_out), 64'd1);
      chk($sformatf("t2_gid%0d", k),    64'(grant_id_out), 64'(k % 4));
      chk($sformatf("t2_wdata%0d", k),  ctrl_wdata_out, 64'hD0 + 64'(k % 4));
      tick();
    end
    req_valid = '0;

    // Two reads from requester 1, responses routed back in order
    do_reset();
    do_grant(1, 19'h00010, 64'h0, "t3_rd0");
    do_grant(1, 19'h00020, 64'h0, "t3_rd1");
    rvalid = 1'b1;
    rdata  = 64'hAAAA;
    tick();
    rdata  = 64'hBBBB;
    #2;
    chk("t3_rsp0",  64'(rsp_valid_out), 64'(4'b0010));
    chk("t3_data0", rsp_data_out, 64'hAAAA);
    tick();
    rvalid = 1'b0;
    #2;
    chk("t3_rsp1",  64'(rsp_valid_out), 64'(4'b0010));
    chk("t3_data1", rsp_data_out, 64'hBBBB);
    tick();
    #2;
    chk("t3_rsp_idle", 64'(rsp_valid_out), 64'd0);
    chk("t3_hold",     rsp_data_out, 64'hBBBB);
    chk("t3_err",      64'(rsp_err_out), 64'd0);
    tick();

    // Full ID FIFO: write still granted, read held off until a pop
    do_reset();
    for (int k = 0; k < 8; k++) do_grant(k % 4, 19'(256 + k * 16), 64'h0, $sformatf("t4_fill%0d", k));
    req_addr[3*AW +: AW]  = 19'h00300;
    req_addr[1*AW +: AW]  = 19'h40000;
    req_wdata[1*DW +: DW] = 64'h55;
    req_valid = 4'b1010;
    wait_ready("t4_wr_wait", ok);
    chk("t4_wr_ready", 64'(req_ready_out), 64'(4'b0010));
    tick();
    req_valid[1] = 1'b0;
    #2;
    chk("t4_wr_addr",  64'(ctrl_addr_out), 64'h40000);
    chk("t4_wr_wdata", ctrl_wdata_out, 64'h55);
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      #2;
      if (req_ready_out != '0) seen = 1'b1;
    end
    chk("t4_rd_blocked", 64'(seen), 64'd0);
    tick();
    rvalid = 1'b1;
    rdata  = 64'h77;
    #2;
    chk("t4_pop_cycle_ready", 64'(req_ready_out), 64'd0);
    tick();
    rvalid = 1'b0;
    #2;
    chk("t4_rsp",      64'(rsp_valid_out), 64'(4'b0001));
    chk("t4_rsp_data", rsp_data_out, 64'h77);
    chk("t4_rd_ready", 64'(req_ready_out), 64'(4'b1000));
    tick();
    req_valid = '0;
    #2;
    chk("t4_rd_addr", 64'(ctrl_addr_out), 64'h00300);
    tick();

    // Refresh becomes due in IDLE alongside a request: refresh wins
    do_reset();
    repeat (1024) tick();
    req_addr[0*AW +: AW] = 19'h00100;
    req_valid = 4'b0001;
    #2;
    chk("t5_due_ready",   64'(req_ready_out), 64'd0);
    chk("t5_due_refresh", 64'(refresh_active_out), 64'd0);
    for (int n = 0; n < 16; n++) begin
      tick();
      #2;
      chk($sformatf("t5_refresh%0d", n), 64'(refresh_active_out), 64'd1);
      chk($sformatf("t5_noready%0d", n), 64'(req_ready_out), 64'd0);
    end
    tick();
    #2;
    chk("t5_refresh_end", 64'(refresh_active_out), 64'd0);
    chk("t5_grant",       64'(req_ready_out), 64'(4'b0001));
    tick();
    req_valid = '0;
    #2;
    chk("t5_cvalid", 64'(ctrl_valid_out), 64'd1);
    tick();

    // Reset during HOLD with two reads outstanding
    do_reset();
    do_grant(0, 19'h00100, 64'h0, "t6_rd0");
    do_grant(2, 19'h00200, 64'h0, "t6_rd1");
    rst_N_in = 1'b1;
    #2;
    chk("t6_cvalid", 64'(ctrl_valid_out), 64'd0);
    chk("t6_addr",   64'(ctrl_addr_out), 64'd0);
    chk("t6_gid",    64'(grant_id_out), 64'd0);
    chk("t6_rsp",    64'(rsp_valid_out), 64'd0);
    tick();
    rst_N_in = 1'b0;
    rvalid = 1'b1;
    rdata  = 64'hDEAD;
    #2;
    chk("t6_err_before", 64'(rsp_err_out), 64'd0);
    tick();
    rvalid = 1'b0;
    #2;
    chk("t6_no_rsp",   64'(rsp_valid_out), 64'd0);
    chk("t6_err",      64'(rsp_err_out), 64'd1);
    chk("t6_no_rdata", rsp_data_out, 64'd0);
    tick();
    req_valid = 4'b0011;
    #2;
    chk("t6_rr_reset", 64'(req_ready_out), 64'(4'b0001));
    tick();
    req_valid = '0;
    tick();
    #2;
    chk("t6_err_sticky", 64'(rsp_err_out), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
